pixel_delay_line: RTL and testbench

Parametrised, stallable shift-register pipeline that delays a pixel stream by DEPTH enabled clock edges. It exposes every stage as a tap, tracks validity per stage, and reports when all stages hold valid samples. It is the generalised successor to the single-bit constant flip-flop. It sits between the pixel source and the Sobel convolution core, where DEPTH=3 instances form the horizontal window of each kernel row.

---
 rtl/pixel_delay_line.sv | 58 +++++
 tb/tb_pixel_delay_line.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pixel_delay_line.sv
// Stallable pixel delay line: DEPTH register stages with per-stage validity,
// every stage exposed as a tap, and a fill counter that reports when the window is full.
module pixel_delay_line #(
  parameter int                 DATA_W    = 8,
  parameter int                 DEPTH     = 3,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0,
  localparam int                CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic [DEPTH*DATA_W-1:0]  taps,
  output logic [DEPTH-1:0]         tap_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic [CNT_W-1:0]         fill_cnt,
  output logic                     primed
);

  logic [DATA_W-1:0] stage [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [CNT_W-1:0]  cnt;

  // Reset and flush share one clear path; reset is listed first for clarity
  // even though both produce the same state.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage[k] <= RESET_VAL;
      end
      vld <= '0;
      cnt <= '0;
    end else if (en) begin
      stage[0] <= in_data;
      vld[0]   <= in_valid;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= stage[k-1];
        vld[k]   <= vld[k-1];
      end
      // One sample in, one out per shift, so the count stays within 0..DEPTH.
      cnt <= cnt + CNT_W'(in_valid) - CNT_W'(vld[DEPTH-1]);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*DATA_W +: DATA_W] = stage[k];
  end

  assign tap_valid = vld;
  assign out_data  = stage[DEPTH-1];
  assign out_valid = vld[DEPTH-1];
  assign fill_cnt  = cnt;
  assign primed    = (cnt == CNT_W'(DEPTH));

endmodule

// File: tb/tb_pixel_delay_line.sv
// Directed bench: a DEPTH=3 byte-wide instance with RESET_VAL=AA and a
// DEPTH=1, 12-bit instance, each compared against hand-computed values.
module tb_pixel_delay_line;

  logic        clk = 1'b0;
  logic        rst_n, en, flush;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [23:0] taps;
  logic [2:0]  tap_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  fill_cnt;
  logic        primed;

  logic        b_in_valid;
  logic [11:0] b_in_data;
  logic [11:0] b_taps;
  logic [0:0]  b_tap_valid;
  logic [11:0] b_out_data;
  logic        b_out_valid;
  logic [0:0]  b_fill_cnt;
  logic        b_primed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pixel_delay_line #(.DATA_W(8), .DEPTH(3), .RESET_VAL(8'hAA)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .taps(taps), .tap_valid(tap_valid), .out_data(out_data),
    .out_valid(out_valid), .fill_cnt(fill_cnt), .primed(primed)
  );

  pixel_delay_line #(.DATA_W(12), .DEPTH(1), .RESET_VAL(12'h000)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(b_in_valid), .in_data(b_in_data),
    .taps(b_taps), .tap_valid(b_tap_valid), .out_data(b_out_data),
    .out_valid(b_out_valid), .fill_cnt(b_fill_cnt), .primed(b_primed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; en = 1'b1;
    in_valid = 1'b1; in_data = 8'h5A;
    b_in_valid = 1'b1; b_in_data = 12'h123;
    tick(); tick();
    checks++; if (taps !== 24'hAAAAAA) begin errors++; $display("FAIL reset_taps got=%h exp=%h", taps, 24'hAAAAAA); end
    checks++; if (tap_valid !== 3'b000) begin errors++; $display("FAIL reset_tap_valid got=%b exp=000", tap_valid); end
    checks++; if (fill_cnt !== 2'd0) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill_cnt); end
    checks++; if (primed !== 1'b0) begin errors++; $display("FAIL reset_primed got=%b exp=0", primed); end
    checks++; if (out_data !== 8'hAA || out_valid !== 1'b0) begin errors++; $display("FAIL reset_out got=%h/%b exp=aa/0", out_data, out_valid); end
    checks++; if (b_out_data !== 12'h000 || b_primed !== 1'b0 || b_fill_cnt !== 1'b0) begin errors++; $display("FAIL reset_b got=%h/%b/%b exp=000/0/0", b_out_data, b_primed, b_fill_cnt); end
    b_in_valid = 1'b0;
  endtask

  task automatic test_fill_stream();
    rst_n = 1'b1; en = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; tick();
    checks++; if (taps[7:0] !== 8'h11 || fill_cnt !== 2'd1 || primed !== 1'b0) begin errors++; $display("FAIL fill_1 got=%h/%0d/%b exp=11/1/0", taps[7:0], fill_cnt, primed); end
    in_data = 8'h22; tick();
    checks++; if (tap_valid !== 3'b011 || fill_cnt !== 2'd2 || primed !== 1'b0) begin errors++; $display("FAIL fill_2 got=%b/%0d/%b exp=011/2/0", tap_valid, fill_cnt, primed); end
    in_data = 8'h33; tick();
    checks++; if (taps !== 24'h112233) begin errors++; $display("FAIL fill_3_taps got=%h exp=112233", taps); end
    checks++; if (fill_cnt !== 2'd3 || primed !== 1'b1) begin errors++; $display("FAIL fill_3_primed got=%0d/%b exp=3/1", fill_cnt, primed); end
    checks++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin errors++; $display("FAIL fill_3_out got=%h/%b exp=11/1", out_data, out_valid); end
    in_data = 8'h44; tick();
    checks++; if (out_data !== 8'h22 || fill_cnt !== 2'd3 || taps !== 24'h223344) begin errors++; $display("FAIL stream_4 got=%h/%0d/%h exp=22/3/223344", out_data, fill_cnt, taps); end
  endtask

  task automatic test_stall();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'hF0 ^ 8'(i * 8'h13);
      in_valid = i[0];
      tick();
      checks++; if (taps !== 24'h223344 || tap_valid !== 3'b111 || fill_cnt !== 2'd3) begin errors++; $display("FAIL stall_hold_%0d got=%h/%b/%0d exp=223344/111/3", i, taps, tap_valid, fill_cnt); end
    end
    en = 1'b1; in_valid = 1'b1;
    in_data = 8'h45; tick();
    checks++; if (out_data !== 8'h33 || out_valid !== 1'b1) begin errors++; $display("FAIL stall_resume_1 got=%h/%b exp=33/1", out_data, out_valid); end
    in_data = 8'h46; tick();
    checks++; if (out_data !== 8'h44 || taps !== 24'h444546) begin errors++; $display("FAIL stall_resume_2 got=%h/%h exp=44/444546", out_data, taps); end
  endtask

  task automatic test_bubble();
    en = 1'b1;
    in_valid = 1'b1; in_data = 8'h55; tick();
    checks++; if (tap_valid !== 3'b111 || primed !== 1'b1) begin errors++; $display("FAIL bubble_pre got=%b/%b exp=111/1", tap_valid, primed); end
    in_valid = 1'b0; in_data = 8'h00; tick();
    checks++; if (tap_valid !== 3'b110 || fill_cnt !== 2'd2 || primed !== 1'b0 || out_data !== 8'h46) begin errors++; $display("FAIL bubble_e1 got=%b/%0d/%b/%h exp=110/2/0/46", tap_valid, fill_cnt, primed, out_data); end
    in_valid = 1'b1; in_data = 8'h66; tick();
    checks++; if (tap_valid !== 3'b101 || fill_cnt !== 2'd2 || primed !== 1'b0 || out_data !== 8'h55) begin errors++; $display("FAIL bubble_e2 got=%b/%0d/%b/%h exp=101/2/0/55", tap_valid, fill_cnt, primed, out_data); end
    in_data = 8'h67; tick();
    checks++; if (tap_valid !== 3'b011 || fill_cnt !== 2'd2 || primed !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL bubble_e3 got=%b/%0d/%b/%b exp=011/2/0/0", tap_valid, fill_cnt, primed, out_valid); end
    in_data = 8'h68; tick();
    checks++; if (tap_valid !== 3'b111 || fill_cnt !== 2'd3 || primed !== 1'b1 || out_data !== 8'h66) begin errors++; $display("FAIL bubble_e4 got=%b/%0d/%b/%h exp=111/3/1/66", tap_valid, fill_cnt, primed, out_data); end
  endtask

  task automatic test_flush();
    en = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; tick();
    checks++; if (taps !== 24'hAAAAAA || tap_valid !== 3'b000 || fill_cnt !== 2'd0 || primed !== 1'b0) begin errors++; $display("FAIL flush_en got=%h/%b/%0d/%b exp=aaaaaa/000/0/0", taps, tap_valid, fill_cnt, primed); end
    flush = 1'b0;
    in_data = 8'h78; tick();
    in_data = 8'h79; tick();
    in_data = 8'h7A; tick();
    checks++; if (taps !== 24'h78797A || primed !== 1'b1) begin errors++; $display("FAIL refill got=%h/%b exp=78797a/1", taps, primed); end
    rst_n = 1'b0; flush = 1'b1; in_data = 8'h77; tick();
    checks++; if (taps !== 24'hAAAAAA || tap_valid !== 3'b000 || fill_cnt !== 2'd0 || primed !== 1'b0) begin errors++; $display("FAIL rst_flush got=%h/%b/%0d/%b exp=aaaaaa/000/0/0", taps, tap_valid, fill_cnt, primed); end
    rst_n = 1'b1; flush = 1'b0; in_data = 8'h88; tick();
    checks++; if (taps !== 24'hAAAA88 || tap_valid !== 3'b001 || fill_cnt !== 2'd1) begin errors++; $display("FAIL post_flush got=%h/%b/%0d exp=aaaa88/001/1", taps, tap_valid, fill_cnt); end
  endtask

  task automatic test_depth1();
    en = 1'b1; in_valid = 1'b0;
    b_in_valid = 1'b1; b_in_data = 12'hABC; tick();
    checks++; if (b_out_data !== 12'hABC || b_taps !== 12'hABC || b_primed !== 1'b1 || b_fill_cnt !== 1'b1) begin errors++; $display("FAIL d1_capture got=%h/%h/%b/%b exp=abc/abc/1/1", b_out_data, b_taps, b_primed, b_fill_cnt); end
    b_in_valid = 1'b1; b_in_data = 12'h456; tick();
    checks++; if (b_out_data !== 12'h456 || b_primed !== 1'b1 || b_fill_cnt !== 1'b1) begin errors++; $display("FAIL d1_stream got=%h/%b/%b exp=456/1/1", b_out_data, b_primed, b_fill_cnt); end
    b_in_valid = 1'b0; b_in_data = 12'h000; tick();
    checks++; if (b_primed !== 1'b0 || b_out_valid !== 1'b0 || b_fill_cnt !== 1'b0) begin errors++; $display("FAIL d1_bubble got=%b/%b/%b exp=0/0/0", b_primed, b_out_valid, b_fill_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = 8'h00;
    b_in_valid = 1'b0; b_in_data = 12'h000;
    test_reset();
    test_fill_stream();
    test_stall();
    test_bubble();
    test_flush();
    test_depth1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
